drum_dot_acc: RTL and testbench

Streaming accumulator directly downstream of the DRUM approximate multiplier. Consumes one unsigned product per accepted beat and sums a burst of products terminated by a last flag. Emits the dot-product result, its beat count and a saturation flag through a one-entry output register with valid/ready handshake. Forms the MAC back-end for approximate filter and convolution kernels.

---
 rtl/drum_pkg.sv | 30 +++
 rtl/drum_sat_add.sv | 29 ++
 rtl/drum_dot_acc.sv | 138 +++++++++++++
 tb/tb_drum_dot_acc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drum_pkg
//  Purpose  : Shared constants and types for the DRUM multiplier back-end.
//             This file sets the multiplier operand geometry and the default
//             accumulator sizing. It also holds the burst-state encoding used
//             by drum_dot_acc.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package drum_pkg;

  // DRUM multiplier geometry: k-bit truncated core, m x n operand widths.
  localparam int K_IN   = 4;
  localparam int M_IN   = 16;
  localparam int N_IN   = 16;
  localparam int PROD_W = M_IN + N_IN;

  // Default accumulator sizing for the dot-product back-end.
  localparam int DEF_ACC_W = 40;
  localparam int DEF_CNT_W = 8;

  // Burst tracking: IDLE means no partial burst is open.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_t;

endpackage : drum_pkg
`default_nettype wire

// File: rtl/drum_sat_add.sv
`default_nettype none
// ============================================================================
//  Module   : drum_sat_add
//  Purpose  : Combinational unsigned saturating adder. The sum is formed one
//             bit wider than the operands. A carry out of the top bit clamps
//             the result to all ones and raises the overflow flag.
//  Ports    : i_a    [W-1:0]  operand A (unsigned)
//             i_b    [W-1:0]  operand B (unsigned)
//             o_sum  [W-1:0]  clamped sum
//             o_ovf           1 when the true sum exceeded 2^W-1
//  Revision : 1.0 - initial release
// ============================================================================
module drum_sat_add #(
  parameter int W = 40
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf  = w_full[W];
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule : drum_sat_add
`default_nettype wire

// File: rtl/drum_dot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : drum_dot_acc
//  Purpose  : Streaming dot-product accumulator placed behind the DRUM
//             multiplier. It sums the unsigned products of a burst that ends
//             with a last flag. The result is emitted through a one-entry
//             valid/ready output register, together with the beat count and a
//             saturation flag.
//  Ports    : clk        rising-edge clock
//             rst        asynchronous active-high reset
//             in_valid   product beat valid
//             in_ready   block can accept a beat this cycle
//             in_prod    [PROD_W-1:0] unsigned product
//             in_last    final beat of current burst
//             out_valid  result register holds a result
//             out_ready  consumer takes result this cycle
//             out_sum    [ACC_W-1:0] accumulated sum (saturating)
//             out_cnt    [CNT_W-1:0] beats in burst (saturating)
//             out_sat    sum was clipped during the burst
//  Revision : 1.0 - initial release
// ============================================================================
module drum_dot_acc #(
  parameter int PROD_W = drum_pkg::PROD_W,
  parameter int ACC_W  = drum_pkg::DEF_ACC_W,
  parameter int CNT_W  = drum_pkg::DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_sat
);

  import drum_pkg::*;

  // Running burst state
  acc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  // Output register
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_sat;

  logic             w_in_ready;
  logic             w_accept;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic [CNT_W-1:0] w_cnt_next;

  // The output register is free when it is empty or is being drained this
  // cycle. This is the only combinational path from an input to an output.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  // Zero-extend the product to the accumulator width. A zero-width pad is
  // not legal, so the equal-width case is handled separately.
  generate
    if (ACC_W > PROD_W) begin : g_ext_pad
      assign w_prod_ext = {{(ACC_W - PROD_W){1'b0}}, in_prod};
    end else begin : g_ext_none
      assign w_prod_ext = in_prod[ACC_W-1:0];
    end
  endgenerate

  // A new burst always starts from zero. In IDLE r_acc is already zero, but
  // keying on the state keeps a stray value from ever leaking into a burst.
  assign w_acc_base = (r_state == ST_IDLE) ? '0 : r_acc;

  // The beat counter sticks at its maximum value instead of wrapping.
  assign w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  drum_sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .i_a   (w_acc_base),
    .i_b   (w_prod_ext),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cnt   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (in_last) begin
          r_out_sum <= w_sum;
          r_out_cnt <= w_cnt_next;
          r_out_sat <= r_sat | w_ovf;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_sat     <= 1'b0;
          r_state   <= ST_IDLE;
        end else begin
          r_acc     <= w_sum;
          r_cnt     <= w_cnt_next;
          r_sat     <= r_sat | w_ovf;
          r_state   <= ST_ACC;
        end
      end

      // A last beat accepted in the same cycle as a drain reloads the
      // register, so back-to-back results leave no bubble.
      if (w_accept && in_last) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cnt   = r_out_cnt;
  assign out_sat   = r_out_sat;

endmodule : drum_dot_acc
`default_nettype wire

// File: tb/tb_drum_dot_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drum_dot_acc
//  Purpose  : Self-checking bench for drum_dot_acc. It drives a default-width
//             instance (ACC_W=40) and a narrow instance (ACC_W=32) with the
//             same stimulus. Each instance's results are checked against
//             hand-computed values.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_drum_dot_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [39:0] out_sum;
  logic [7:0]  out_cnt;
  logic        out_sat;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] out_sum32;
  logic [7:0]  out_cnt32;
  logic        out_sat32;

  int n_vec;
  int n_err;

  drum_dot_acc #(
    .PROD_W (32),
    .ACC_W  (40),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat)
  );

  drum_dot_acc #(
    .PROD_W (32),
    .ACC_W  (32),
    .CNT_W  (8)
  ) dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .out_sum   (out_sum32),
    .out_cnt   (out_cnt32),
    .out_sat   (out_sat32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] p [4];
    logic [39:0] sum;
    logic [7:0]  cnt;
    logic        sat;
    logic [31:0] sum32;
    logic        sat32;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one beat at the falling edge and hold it until it is accepted.
  task automatic send_beat(input logic [31:0] p, input logic last);
    int waited;
    waited    = 0;
    in_valid  = 1'b1;
    in_prod   = p;
    in_last   = last;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept_timeout: got in_ready=0, expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    //                n  products                                sum40            cnt sat sum32         sat32
    vecs[0] = '{3, '{32'd100, 32'd200, 32'd300, 32'd0},           40'd600,          8'd3, 1'b0, 32'd600,      1'b0};
    vecs[1] = '{1, '{32'd5, 32'd0, 32'd0, 32'd0},                 40'd5,            8'd1, 1'b0, 32'd5,        1'b0};
    vecs[2] = '{4, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                40'h3_FFFF_FFFC, 8'd4, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{2, '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0},         40'h1_0000_0001,  8'd2, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{1, '{32'd1, 32'd0, 32'd0, 32'd0},                 40'd1,            8'd1, 1'b0, 32'd1,        1'b0};
    vecs[5] = '{2, '{32'd1234, 32'd4321, 32'd0, 32'd0},           40'd5555,         8'd2, 1'b0, 32'd5555,     1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum",   {24'd0, out_sum},   64'd0);
    check("rst_out_cnt",   {56'd0, out_cnt},   64'd0);
    check("rst_out_sat",   {63'd0, out_sat},   64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a burst discards the partial sum
    send_beat(32'd50, 1'b0);
    send_beat(32'd60, 1'b0);
    #2 rst = 1'b1;
    #2;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_beat(32'd5, 1'b1);
    check("midrst_next_valid", {63'd0, out_valid}, 64'd1);
    check("midrst_next_sum",   {24'd0, out_sum},   64'd5);
    check("midrst_next_cnt",   {56'd0, out_cnt},   64'd1);
    check("midrst_next_sat",   {63'd0, out_sat},   64'd0);
    @(negedge clk);

    // Table-driven bursts with a free-running consumer
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < vecs[i].n; b++)
        send_beat(vecs[i].p[b], (b == vecs[i].n - 1));
      check($sformatf("v%0d_valid", i), {63'd0, out_valid},  64'd1);
      check($sformatf("v%0d_sum", i),   {24'd0, out_sum},    {24'd0, vecs[i].sum});
      check($sformatf("v%0d_cnt", i),   {56'd0, out_cnt},    {56'd0, vecs[i].cnt});
      check($sformatf("v%0d_sat", i),   {63'd0, out_sat},    {63'd0, vecs[i].sat});
      check($sformatf("v%0d_sum32", i), {32'd0, out_sum32},  {32'd0, vecs[i].sum32});
      check($sformatf("v%0d_sat32", i), {63'd0, out_sat32},  {63'd0, vecs[i].sat32});
      check($sformatf("v%0d_cnt32", i), {56'd0, out_cnt32},  {56'd0, vecs[i].cnt});
      @(negedge clk);
      check($sformatf("v%0d_drop", i),  {63'd0, out_valid},  64'd0);
    end

    // Backpressure: a pending result freezes the block
    out_ready = 1'b0;
    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b1);
    in_valid = 1'b1;
    in_prod  = 32'd999;
    in_last  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_in_ready_%0d", c),  {63'd0, in_ready},  64'd0);
      check($sformatf("bp_out_valid_%0d", c), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp_out_sum_%0d", c),   {24'd0, out_sum},   64'd30);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drained", {63'd0, out_valid}, 64'd0);
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b1);
    check("bp_next_sum", {24'd0, out_sum}, 64'd3);
    check("bp_next_cnt", {56'd0, out_cnt}, 64'd2);
    @(negedge clk);

    // Back-to-back single-beat bursts with no bubble
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_prod  = 32'd7;
    @(negedge clk);
    check("b2b_valid0", {63'd0, out_valid}, 64'd1);
    check("b2b_sum0",   {24'd0, out_sum},   64'd7);
    in_prod = 32'd9;
    @(negedge clk);
    check("b2b_valid1", {63'd0, out_valid}, 64'd1);
    check("b2b_sum1",   {24'd0, out_sum},   64'd9);
    check("b2b_cnt1",   {56'd0, out_cnt},   64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("b2b_drop", {63'd0, out_valid}, 64'd0);

    // Beat counter saturates at 255 while the sum keeps counting
    for (int b = 0; b < 300; b++)
      send_beat(32'd1, (b == 299));
    check("cntsat_valid", {63'd0, out_valid}, 64'd1);
    check("cntsat_cnt",   {56'd0, out_cnt},   64'd255);
    check("cntsat_sum",   {24'd0, out_sum},   64'd300);
    check("cntsat_sat",   {63'd0, out_sat},   64'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_drum_dot_acc
`default_nettype wire
